// File: rtl/exception_sequencer_pkg.sv
// Shared mode codes, vector offsets, CPSR bit positions and payload types for the exception sequencer.
package exception_sequencer_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned MODE_W     = 5;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned BE_W       = 4;
  localparam int unsigned REQ_W      = 6;
  localparam int unsigned OFF_W      = 5;

  // Processor mode codes
  localparam logic [MODE_W-1:0] MODE_USE = 5'b10000;
  localparam logic [MODE_W-1:0] MODE_FIQ = 5'b10001;
  localparam logic [MODE_W-1:0] MODE_IRQ = 5'b10010;
  localparam logic [MODE_W-1:0] MODE_SVC = 5'b10011;
  localparam logic [MODE_W-1:0] MODE_ABT = 5'b10111;
  localparam logic [MODE_W-1:0] MODE_UND = 5'b11011;
  localparam logic [MODE_W-1:0] MODE_SYS = 5'b11111;

  // Vector offsets from VEC_BASE
  localparam logic [OFF_W-1:0] VEC_RESET = 5'h00;
  localparam logic [OFF_W-1:0] VEC_UND   = 5'h04;
  localparam logic [OFF_W-1:0] VEC_SWI   = 5'h08;
  localparam logic [OFF_W-1:0] VEC_PABT  = 5'h0C;
  localparam logic [OFF_W-1:0] VEC_DABT  = 5'h10;
  localparam logic [OFF_W-1:0] VEC_IRQ   = 5'h18;
  localparam logic [OFF_W-1:0] VEC_FIQ   = 5'h1C;

  // CPSR control bit indices
  localparam int unsigned CPSR_I = 7;
  localparam int unsigned CPSR_F = 6;

  // exc_req bit indices
  localparam int unsigned REQ_UND  = 0;
  localparam int unsigned REQ_SWI  = 1;
  localparam int unsigned REQ_PABT = 2;
  localparam int unsigned REQ_DABT = 3;
  localparam int unsigned REQ_IRQ  = 4;
  localparam int unsigned REQ_FIQ  = 5;

  localparam logic [REG_ADDR_W-1:0] LR_ADDR = 5'd14;

  typedef enum logic [2:0] {
    ST_BOOT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_E_MODE  = 3'd2,
    ST_E_SAVE  = 3'd3,
    ST_E_PC    = 3'd4,
    ST_R_READ  = 3'd5,
    ST_R_WRITE = 3'd6
  } seq_state_e;

  // Winning exception after masking and priority
  typedef struct packed {
    logic              valid;
    logic              fiq;
    logic [MODE_W-1:0] mode;
    logic [OFF_W-1:0]  offset;
  } exc_sel_t;

  // Registered control/data bundle driven toward the regfile and pipeline
  typedef struct packed {
    logic                  exc_ack;
    logic                  eret_ack;
    logic                  busy;
    logic [REG_ADDR_W-1:0] rd_r_addr;
    logic [REG_ADDR_W-1:0] rd_w_addr;
    logic [WORD_W-1:0]     rd_in;
    logic [WORD_W-1:0]     cpsr_in;
    logic [WORD_W-1:0]     spsr_in;
    logic [WORD_W-1:0]     pc_in;
    logic                  cpsr_we;
    logic                  spsr_we;
    logic [BE_W-1:0]       cpsr_be;
    logic [BE_W-1:0]       spsr_be;
    logic [BE_W-1:0]       rd_be;
    logic                  pc_we;
  } seq_out_t;

  // CPSR control byte {I, F, T=0, mode}
  function automatic logic [7:0] cpsr_ctl(input logic i_bit, input logic f_bit,
                                          input logic [MODE_W-1:0] mode);
    return {i_bit, f_bit, 1'b0, mode};
  endfunction

endpackage

// File: rtl/exc_priority_enc.sv
// Masked fixed-priority encoder: dabt > fiq > irq > pabt > und > swi.
module exc_priority_enc
  import exception_sequencer_pkg::*;
(
  input  logic [REQ_W-1:0] exc_req,
  input  logic             i_mask,
  input  logic             f_mask,
  output exc_sel_t         sel
);

  // Pick the highest-priority unmasked request
  always_comb begin
    sel = '0;
    if (exc_req[REQ_DABT]) begin
      sel.valid  = 1'b1;
      sel.mode   = MODE_ABT;
      sel.offset = VEC_DABT;
    end else if (exc_req[REQ_FIQ] && !f_mask) begin
      sel.valid  = 1'b1;
      sel.fiq    = 1'b1;
      sel.mode   = MODE_FIQ;
      sel.offset = VEC_FIQ;
    end else if (exc_req[REQ_IRQ] && !i_mask) begin
      sel.valid  = 1'b1;
      sel.mode   = MODE_IRQ;
      sel.offset = VEC_IRQ;
    end else if (exc_req[REQ_PABT]) begin
      sel.valid  = 1'b1;
      sel.mode   = MODE_ABT;
      sel.offset = VEC_PABT;
    end else if (exc_req[REQ_UND]) begin
      sel.valid  = 1'b1;
      sel.mode   = MODE_UND;
      sel.offset = VEC_UND;
    end else if (exc_req[REQ_SWI]) begin
      sel.valid  = 1'b1;
      sel.mode   = MODE_SVC;
      sel.offset = VEC_SWI;
    end
  end

endmodule

// File: rtl/exception_sequencer.sv
// Sequences ARM exception entry, exception return and boot through the regfile write ports.
module exception_sequencer
  import exception_sequencer_pkg::*;
#(
  parameter logic [31:0] VEC_BASE = 32'h0000_0000
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [REQ_W-1:0]      exc_req,
  input  logic [WORD_W-1:0]     ret_addr,
  input  logic                  eret_req,
  output logic                  exc_ack,
  output logic                  eret_ack,
  output logic                  busy,
  input  logic [WORD_W-1:0]     CPSR_out,
  input  logic [WORD_W-1:0]     SPSR_out,
  input  logic [WORD_W-1:0]     Rd_out,
  output logic [REG_ADDR_W-1:0] Rd_r_addr,
  output logic [REG_ADDR_W-1:0] Rd_w_addr,
  output logic [WORD_W-1:0]     Rd_in,
  output logic [WORD_W-1:0]     CPSR_in,
  output logic [WORD_W-1:0]     SPSR_in,
  output logic [WORD_W-1:0]     PC_in,
  output logic                  CPSR_write_en,
  output logic                  SPSR_write_en,
  output logic [BE_W-1:0]       CPSR_byte_w_en,
  output logic [BE_W-1:0]       SPSR_byte_w_en,
  output logic [BE_W-1:0]       Rd_byte_w_en,
  output logic                  PC_w_en
);

  seq_state_e          state_q, state_d;
  seq_out_t            out_q, out_d;
  exc_sel_t            sel;
  logic                latch_exc;
  logic [WORD_W-1:0]   saved_cpsr_q;
  logic [OFF_W-1:0]    exc_off_q;
  logic [MODE_W-1:0]   cur_mode;
  logic                has_spsr;

  exc_priority_enc u_prio (
    .exc_req (exc_req),
    .i_mask  (CPSR_out[CPSR_I]),
    .f_mask  (CPSR_out[CPSR_F]),
    .sel     (sel)
  );

  assign cur_mode = CPSR_out[MODE_W-1:0];
  assign has_spsr = (cur_mode != MODE_USE) && (cur_mode != MODE_SYS);

  // State, registered outputs and entry context; reset clears everything and parks in BOOT
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q      <= ST_BOOT;
      out_q        <= '0;
      saved_cpsr_q <= '0;
      exc_off_q    <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      if (latch_exc) begin
        saved_cpsr_q <= CPSR_out;
        exc_off_q    <= sel.offset;
      end
    end
  end

  // Next state plus the output bundle for that next state, so outputs track state with no lag
  always_comb begin
    state_d   = state_q;
    out_d     = '0;
    latch_exc = 1'b0;

    unique case (state_q)
      // BOOT persists until its actions have been presented once (busy_q marks that)
      ST_BOOT:    state_d = out_q.busy ? ST_IDLE : ST_BOOT;
      ST_IDLE: begin
        if (sel.valid) begin
          state_d   = ST_E_MODE;
          latch_exc = 1'b1;
        end else if (eret_req) begin
          state_d = ST_R_READ;
        end
      end
      ST_E_MODE:  state_d = ST_E_SAVE;
      ST_E_SAVE:  state_d = ST_E_PC;
      ST_E_PC:    state_d = ST_IDLE;
      ST_R_READ:  state_d = ST_R_WRITE;
      ST_R_WRITE: state_d = ST_IDLE;
      default:    state_d = ST_BOOT;
    endcase

    out_d.busy = (state_d != ST_IDLE);

    unique case (state_d)
      ST_BOOT: begin
        out_d.cpsr_in = WORD_W'(cpsr_ctl(1'b1, 1'b1, MODE_SVC));
        out_d.cpsr_be = 4'b0001;
        out_d.pc_in   = VEC_BASE + WORD_W'(VEC_RESET);
        out_d.pc_we   = 1'b1;
      end
      ST_E_MODE: begin
        out_d.cpsr_in = WORD_W'(cpsr_ctl(1'b1, CPSR_out[CPSR_F] | sel.fiq, sel.mode));
        out_d.cpsr_be = 4'b0001;
      end
      ST_E_SAVE: begin
        out_d.spsr_in   = saved_cpsr_q;
        out_d.spsr_be   = 4'b1111;
        out_d.rd_w_addr = LR_ADDR;
        out_d.rd_in     = ret_addr;
        out_d.rd_be     = 4'b1111;
      end
      ST_E_PC: begin
        out_d.pc_in   = VEC_BASE + WORD_W'(exc_off_q);
        out_d.pc_we   = 1'b1;
        out_d.exc_ack = 1'b1;
      end
      ST_R_READ: begin
        out_d.rd_r_addr = LR_ADDR;
      end
      // LR and SPSR are read during R_READ and captured here into the output registers
      ST_R_WRITE: begin
        if (has_spsr) begin
          out_d.cpsr_in = SPSR_out;
          out_d.cpsr_be = 4'b1111;
        end
        out_d.pc_in    = Rd_out;
        out_d.pc_we    = 1'b1;
        out_d.eret_ack = 1'b1;
      end
      default: ;
    endcase

    out_d.cpsr_we = |out_d.cpsr_be;
    out_d.spsr_we = |out_d.spsr_be;
  end

  assign exc_ack        = out_q.exc_ack;
  assign eret_ack       = out_q.eret_ack;
  assign busy           = out_q.busy;
  assign Rd_r_addr      = out_q.rd_r_addr;
  assign Rd_w_addr      = out_q.rd_w_addr;
  assign Rd_in          = out_q.rd_in;
  assign CPSR_in        = out_q.cpsr_in;
  assign SPSR_in        = out_q.spsr_in;
  assign PC_in          = out_q.pc_in;
  assign CPSR_write_en  = out_q.cpsr_we;
  assign SPSR_write_en  = out_q.spsr_we;
  assign CPSR_byte_w_en = out_q.cpsr_be;
  assign SPSR_byte_w_en = out_q.spsr_be;
  assign Rd_byte_w_en   = out_q.rd_be;
  assign PC_w_en        = out_q.pc_we;

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench for exception_sequencer; the bench plays the regfile by driving its read data.
module tb_exception_sequencer;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [5:0]  exc_req;
  logic [31:0] ret_addr;
  logic        eret_req;
  logic        exc_ack, eret_ack, busy;
  logic [31:0] CPSR_out, SPSR_out, Rd_out;
  logic [4:0]  Rd_r_addr, Rd_w_addr;
  logic [31:0] Rd_in, CPSR_in, SPSR_in, PC_in;
  logic        CPSR_write_en, SPSR_write_en, PC_w_en;
  logic [3:0]  CPSR_byte_w_en, SPSR_byte_w_en, Rd_byte_w_en;

  int tests = 0;
  int fails = 0;

  exception_sequencer #(.VEC_BASE(32'h0000_0000)) dut (
    .Clk(Clk), .Rst(Rst), .exc_req(exc_req), .ret_addr(ret_addr), .eret_req(eret_req),
    .exc_ack(exc_ack), .eret_ack(eret_ack), .busy(busy),
    .CPSR_out(CPSR_out), .SPSR_out(SPSR_out), .Rd_out(Rd_out),
    .Rd_r_addr(Rd_r_addr), .Rd_w_addr(Rd_w_addr), .Rd_in(Rd_in),
    .CPSR_in(CPSR_in), .SPSR_in(SPSR_in), .PC_in(PC_in),
    .CPSR_write_en(CPSR_write_en), .SPSR_write_en(SPSR_write_en),
    .CPSR_byte_w_en(CPSR_byte_w_en), .SPSR_byte_w_en(SPSR_byte_w_en),
    .Rd_byte_w_en(Rd_byte_w_en), .PC_w_en(PC_w_en)
  );

  always #5 Clk = ~Clk;

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b0; exc_req = '0; eret_req = 1'b0; ret_addr = '0;
    CPSR_out = 32'h0000_00D3; SPSR_out = '0; Rd_out = '0;
    repeat (3) tick();
    tests++; if ({busy, PC_w_en, CPSR_write_en, exc_ack, eret_ack} !== 5'b0) begin fails++;
      $display("FAIL reset_ctl: got %b want 00000", {busy, PC_w_en, CPSR_write_en, exc_ack, eret_ack}); end
    tests++; if ({CPSR_in, PC_in, CPSR_byte_w_en} !== 68'h0) begin fails++;
      $display("FAIL reset_data: got %h %h %h want 0", CPSR_in, PC_in, CPSR_byte_w_en); end
    Rst = 1'b1;
    tick();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL boot_busy: got %b want 1", busy); end
    tests++; if (CPSR_in[7:0] !== 8'hD3 || CPSR_byte_w_en !== 4'b0001 || CPSR_write_en !== 1'b1) begin fails++;
      $display("FAIL boot_cpsr: got %h/%b/%b want d3/0001/1", CPSR_in[7:0], CPSR_byte_w_en, CPSR_write_en); end
    tests++; if (PC_in !== 32'h0 || PC_w_en !== 1'b1) begin fails++;
      $display("FAIL boot_pc: got %h/%b want 0/1", PC_in, PC_w_en); end
    tests++; if (SPSR_write_en !== 1'b0 || Rd_byte_w_en !== 4'b0) begin fails++;
      $display("FAIL boot_nosave: got %b/%b want 0/0000", SPSR_write_en, Rd_byte_w_en); end
    tick();
    tests++; if (busy !== 1'b0 || PC_w_en !== 1'b0 || CPSR_write_en !== 1'b0) begin fails++;
      $display("FAIL boot_idle: got %b%b%b want 000", busy, PC_w_en, CPSR_write_en); end
  endtask

  task automatic test_irq_entry();
    CPSR_out = 32'h6000_0010; ret_addr = 32'h0000_1004; exc_req = 6'b010000;
    tick();
    tests++; if (busy !== 1'b1 || exc_ack !== 1'b0) begin fails++;
      $display("FAIL irq_mode_ctl: got busy %b ack %b want 1 0", busy, exc_ack); end
    tests++; if (CPSR_in[7:0] !== 8'h92 || CPSR_byte_w_en !== 4'b0001 || CPSR_write_en !== 1'b1) begin fails++;
      $display("FAIL irq_mode_cpsr: got %h/%b/%b want 92/0001/1", CPSR_in[7:0], CPSR_byte_w_en, CPSR_write_en); end
    tick();
    CPSR_out = 32'h6000_0092;
    tests++; if (SPSR_in !== 32'h6000_0010 || SPSR_byte_w_en !== 4'hF || SPSR_write_en !== 1'b1) begin fails++;
      $display("FAIL irq_save_spsr: got %h/%b/%b want 60000010/1111/1", SPSR_in, SPSR_byte_w_en, SPSR_write_en); end
    tests++; if (Rd_w_addr !== 5'd14 || Rd_in !== 32'h1004 || Rd_byte_w_en !== 4'hF || CPSR_write_en !== 1'b0) begin fails++;
      $display("FAIL irq_save_lr: got %0d/%h/%b/%b want 14/1004/1111/0", Rd_w_addr, Rd_in, Rd_byte_w_en, CPSR_write_en); end
    tick();
    tests++; if (PC_in !== 32'h18 || PC_w_en !== 1'b1 || exc_ack !== 1'b1 || busy !== 1'b1) begin fails++;
      $display("FAIL irq_pc: got %h/%b/%b/%b want 18/1/1/1", PC_in, PC_w_en, exc_ack, busy); end
    exc_req = '0;
    tick();
    tests++; if (busy !== 1'b0 || exc_ack !== 1'b0 || PC_w_en !== 1'b0) begin fails++;
      $display("FAIL irq_done: got %b%b%b want 000", busy, exc_ack, PC_w_en); end
  endtask

  task automatic test_mask_priority();
    CPSR_out = 32'h0000_0093; exc_req = 6'b110000;
    tick();
    tests++; if (CPSR_in[7:0] !== 8'hD1) begin fails++;
      $display("FAIL fiq_cpsr: got %h want d1", CPSR_in[7:0]); end
    tick();
    tests++; if (SPSR_in !== 32'h0000_0093) begin fails++;
      $display("FAIL fiq_spsr: got %h want 00000093", SPSR_in); end
    tick();
    tests++; if (PC_in !== 32'h1C || exc_ack !== 1'b1) begin fails++;
      $display("FAIL fiq_pc: got %h/%b want 1c/1", PC_in, exc_ack); end
    exc_req = 6'b010000; CPSR_out = 32'h0000_0093;
    tick();
    repeat (3) begin
      tick();
      tests++; if (busy !== 1'b0 || CPSR_write_en !== 1'b0) begin fails++;
        $display("FAIL irq_masked: got busy %b cpsr_we %b want 0 0", busy, CPSR_write_en); end
    end
    exc_req = '0;
  endtask

  task automatic test_back_to_back();
    CPSR_out = 32'h0000_0010; exc_req = 6'b001010; eret_req = 1'b1; ret_addr = 32'h0000_2008;
    tick();
    tests++; if (CPSR_in[7:0] !== 8'h97 || Rd_r_addr !== 5'd0) begin fails++;
      $display("FAIL b2b_dabt_cpsr: got %h rd_r %0d want 97 0", CPSR_in[7:0], Rd_r_addr); end
    tick();
    CPSR_out = 32'h0000_0097;
    tick();
    tests++; if (PC_in !== 32'h10 || exc_ack !== 1'b1) begin fails++;
      $display("FAIL b2b_dabt_pc: got %h/%b want 10/1", PC_in, exc_ack); end
    exc_req = 6'b000010;
    tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_gap: got busy %b want 0", busy); end
    tick();
    tests++; if (CPSR_in[7:0] !== 8'h93 || busy !== 1'b1) begin fails++;
      $display("FAIL b2b_swi_cpsr: got %h/%b want 93/1", CPSR_in[7:0], busy); end
    tick();
    CPSR_out = 32'h0000_0093;
    tests++; if (SPSR_in !== 32'h0000_0097) begin fails++;
      $display("FAIL b2b_swi_spsr: got %h want 00000097", SPSR_in); end
    tick();
    tests++; if (PC_in !== 32'h08 || exc_ack !== 1'b1) begin fails++;
      $display("FAIL b2b_swi_pc: got %h/%b want 08/1", PC_in, exc_ack); end
    exc_req = '0;
    tick();
    tick();
    tests++; if (Rd_r_addr !== 5'd14 || busy !== 1'b1 || eret_ack !== 1'b0) begin fails++;
      $display("FAIL b2b_eret_read: got %0d/%b/%b want 14/1/0", Rd_r_addr, busy, eret_ack); end
    SPSR_out = 32'h0000_0097; Rd_out = 32'h0000_2008;
    tick();
    tests++; if (eret_ack !== 1'b1 || PC_in !== 32'h2008 || CPSR_in !== 32'h97) begin fails++;
      $display("FAIL b2b_eret_write: got %b/%h/%h want 1/2008/97", eret_ack, PC_in, CPSR_in); end
    eret_req = 1'b0;
    tick();
  endtask

  task automatic test_return();
    CPSR_out = 32'h0000_0093; SPSR_out = 32'h2000_0010; Rd_out = 32'hABCD_DCBA; eret_req = 1'b1;
    tick();
    tests++; if (busy !== 1'b1 || eret_ack !== 1'b0 || PC_w_en !== 1'b0 || Rd_r_addr !== 5'd14) begin fails++;
      $display("FAIL ret_read: got %b/%b/%b/%0d want 1/0/0/14", busy, eret_ack, PC_w_en, Rd_r_addr); end
    tick();
    tests++; if (CPSR_in !== 32'h2000_0010 || CPSR_byte_w_en !== 4'hF || CPSR_write_en !== 1'b1) begin fails++;
      $display("FAIL ret_cpsr: got %h/%b/%b want 20000010/1111/1", CPSR_in, CPSR_byte_w_en, CPSR_write_en); end
    tests++; if (PC_in !== 32'hABCD_DCBA || PC_w_en !== 1'b1 || eret_ack !== 1'b1) begin fails++;
      $display("FAIL ret_pc: got %h/%b/%b want abcddcba/1/1", PC_in, PC_w_en, eret_ack); end
    eret_req = 1'b0; CPSR_out = 32'h2000_0010;
    tick();
    eret_req = 1'b1; Rd_out = 32'h0000_4000;
    tick();
    tick();
    tests++; if (CPSR_write_en !== 1'b0 || CPSR_byte_w_en !== 4'b0) begin fails++;
      $display("FAIL ret_user_cpsr: got %b/%b want 0/0000", CPSR_write_en, CPSR_byte_w_en); end
    tests++; if (PC_in !== 32'h4000 || PC_w_en !== 1'b1 || eret_ack !== 1'b1) begin fails++;
      $display("FAIL ret_user_pc: got %h/%b/%b want 4000/1/1", PC_in, PC_w_en, eret_ack); end
    eret_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    CPSR_out = 32'h0000_0010; exc_req = 6'b000001; ret_addr = 32'h0000_0044;
    tick();
    tick();
    tests++; if (Rd_byte_w_en !== 4'hF) begin fails++;
      $display("FAIL mid_in_save: got %b want 1111", Rd_byte_w_en); end
    Rst = 1'b0; exc_req = '0;
    tick();
    tests++; if ({busy, PC_w_en, exc_ack, SPSR_write_en, CPSR_write_en} !== 5'b0 || PC_in !== 32'h0 || Rd_byte_w_en !== 4'b0) begin fails++;
      $display("FAIL mid_abort: got %b %h %b want 00000 0 0000", {busy, PC_w_en, exc_ack, SPSR_write_en, CPSR_write_en}, PC_in, Rd_byte_w_en); end
    tick();
    tests++; if (PC_w_en !== 1'b0 || exc_ack !== 1'b0) begin fails++;
      $display("FAIL mid_hold: got %b/%b want 0/0", PC_w_en, exc_ack); end
    Rst = 1'b1;
    tick();
    tests++; if (busy !== 1'b1 || CPSR_in[7:0] !== 8'hD3 || PC_w_en !== 1'b1 || PC_in !== 32'h0) begin fails++;
      $display("FAIL mid_reboot: got %b/%h/%b/%h want 1/d3/1/0", busy, CPSR_in[7:0], PC_w_en, PC_in); end
    tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_idle: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_irq_entry();
    test_mask_priority();
    test_back_to_back();
    test_return();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
